pulse_throttle: RTL and testbench
=================================

Name: pulse_throttle

Overview:
- clka-domain event accumulator that sits directly upstream of the clka→clkb pulse synchronizer and drives its a_pul input.
- Counts single-cycle source events and replays them as single-cycle pulses spaced at least GAP clka cycles apart.
- The spacing gives the downstream synchronizer's latch time to clear, so no event merges or drops at the crossing.
- Reports pending depth, saturation overflow and busy status.

Parameters:
- CNT_W, 4, width of pending-event counter; saturates at 2^CNT_W-1.
- GAP, 8, minimum clka cycles between consecutive a_pul rising edges; legal range GAP >= 2, sized by integration for worst-case clka:clkb ratio.

Ports:
- clka  input  1  source clock; all logic on rising edge.
- rstna  input  1  reset, asynchronous, active-low.
- evt_in  input  1  one source event per high cycle.
- en  input  1  firing enable; events still counted when low.
- flush  input  1  synchronous clear of pending count.
- ovf_clr  input  1  synchronous clear of ovf.
- a_pul  output  1  registered single-cycle pulse to the synchronizer.
- pend  output  CNT_W  pending (not yet emitted) event count.
- ovf  output  1  sticky: an event was lost to saturation.
- busy  output  1  (state==HOLD) | (pend!=0).

Behaviour:
- Reset (async, rstna=0): a_pul=0, pend=0, ovf=0, state=IDLE, gap_cnt=0, busy=0. Reset mid-HOLD or with pending events discards everything; no pulse is emitted after release until a new evt_in.
- State machine has two states:
  - IDLE: firing allowed.
  - HOLD: gap timer running.
- Fire condition, evaluated at each edge: fire = en & ~flush & (state==IDLE) & ((pend!=0) | evt_in).
- a_pul <= fire. The pulse is a registered output, high exactly one cycle.
- Bypass latency: evt_in high at edge k while IDLE with pend=0 and en=1 gives a_pul=1 in the cycle following edge k, and pend stays 0.
- Counter update: pend <= sat(pend + evt_in - fire).
  - Simultaneous evt_in and fire leaves pend unchanged.
  - fire never decrements below 0, because fire implies a pending or incoming event.
- Saturation: if pend == 2^CNT_W-1 and evt_in and ~fire, pend holds and ovf <= 1 (event lost).
- ovf: set has priority over ovf_clr in the same cycle.
- flush: pend <= 0 and fire is suppressed; an evt_in on the same edge is discarded (flush wins). flush does not touch state, gap_cnt or ovf.
- Gap timer:
  - On fire: state <= HOLD, gap_cnt <= GAP-1.
  - In HOLD: gap_cnt decrements each edge; when gap_cnt==1 at an edge, state <= IDLE, gap_cnt <= 0.
  - Result: consecutive pulses registered at edges t and t+GAP at the earliest.
- en=0: pending events accumulate and no pulses are issued. HOLD still times out. Firing resumes at the first edge with en=1.
- No combinational path from any input to a_pul.

Decomposition:
- Shared package pulse_sync_pkg holds:
  - state enum {IDLE, HOLD};
  - default constants PT_CNT_W=4 and PT_GAP=8;
  - helper function for saturation max value.
- One natural sub-module: evt_sat_cnt (saturating up/down counter with overflow flag, parameterised by CNT_W), instantiated once.
- FSM and gap timer stay in the top.

Test Plan:
- Single event: reset, en=1, evt_in high at edge 10 → a_pul=1 for cycle after edge 10 only; pend stays 0; busy=1 until HOLD expires at edge 17.
- Burst of 3 consecutive (edges 0-2), GAP=8 → a_pul at edges 0, 8, 16; pend sequence 0,1,2 after edges 0-2, then 1 after edge 8, 0 after edge 16.
- Saturation, CNT_W=2 → 5 events at edges 0-4, 4 pulses total at edges 0, 8, 16, 24:
  - pend reads 1,2,3,3 after edges 1-4, ovf=1 after edge 4;
  - ovf_clr with a simultaneous saturating event keeps ovf=1.
- Simultaneous: pend=2 and evt_in on a firing edge → a_pul=1 and pend stays 2.
- flush + en: en=0, 3 events → pend=3 and no a_pul; flush with evt_in on the same edge → pend=0; en=1 → no pulse.
- Reset mid-operation: pend=3 and in HOLD, assert rstna=0 asynchronously mid-cycle → all outputs 0 immediately; no pulse after release without new evt_in.

Source files
------------

// File: rtl/pulse_sync_pkg.sv
// Shared types and constants for the clka-side pulse throttle feeding the pulse synchronizer.
package pulse_sync_pkg;

  // Gap-timer FSM states: IDLE may fire, HOLD is waiting out the minimum spacing.
  typedef enum logic {IDLE, HOLD} pt_state_e;

  localparam int unsigned PT_CNT_W = 4;
  localparam int unsigned PT_GAP   = 8;

  // Largest value a w-bit saturating counter may hold.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/evt_sat_cnt.sv
// Saturating up/down event counter with a sticky overflow flag.
// Increment and decrement together cancel; clr wins over everything but leaves ovf alone.
module evt_sat_cnt
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CNT_W = PT_CNT_W
) (
  input  logic             clka,
  input  logic             rstna,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ovf_d, ovf_q;
  logic             ovf_set;

  // Next count and overflow; a lost event sets ovf even if ovf_clr is high.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q == CntMax) begin
        ovf_set = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  // Counter and flag state.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/pulse_throttle.sv
// Accumulates clka source events and replays them as registered single-cycle pulses
// spaced at least GAP cycles apart, so the downstream pulse synchronizer never merges two.
module pulse_throttle
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CNT_W = PT_CNT_W,
  parameter int unsigned GAP   = PT_GAP
) (
  input  logic             clka,
  input  logic             rstna,
  input  logic             evt_in,
  input  logic             en,
  input  logic             flush,
  input  logic             ovf_clr,
  output logic             a_pul,
  output logic [CNT_W-1:0] pend,
  output logic             ovf,
  output logic             busy
);

  // GAP >= 2, so GAP-1 always fits and is non-zero.
  localparam int unsigned GapW = (GAP > 2) ? $clog2(GAP) : 1;

  pt_state_e        state_q;
  logic [GapW-1:0]  gap_cnt_q;
  logic             a_pul_q;
  logic             fire;
  logic [CNT_W-1:0] pend_cnt;

  // Fire when idle and something is waiting or arriving; flush suppresses it.
  always_comb begin
    fire = en & ~flush & (state_q == IDLE) & ((pend_cnt != '0) | evt_in);
  end

  // A bypassed event (fire on its arrival edge) cancels its own increment.
  evt_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clka    (clka),
    .rstna   (rstna),
    .inc     (evt_in),
    .dec     (fire),
    .clr     (flush),
    .ovf_clr (ovf_clr),
    .cnt     (pend_cnt),
    .ovf     (ovf)
  );

  // Gap-timer FSM with the registered output pulse.
  always_ff @(posedge clka or negedge rstna) begin
    if (!rstna) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      a_pul_q   <= 1'b0;
    end else begin
      a_pul_q <= fire;
      unique case (state_q)
        IDLE: begin
          if (fire) begin
            state_q   <= HOLD;
            gap_cnt_q <= GapW'(GAP - 1);
          end
        end
        HOLD: begin
          if (gap_cnt_q == GapW'(1)) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_q - GapW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          gap_cnt_q <= '0;
        end
      endcase
    end
  end

  assign a_pul = a_pul_q;
  assign pend  = pend_cnt;
  assign busy  = (state_q == HOLD) | (pend_cnt != '0);

endmodule

// File: tb/tb_pulse_throttle.sv
// Directed bench for pulse_throttle (CNT_W=2, GAP=8): each step pushes the expected
// outputs onto a scoreboard queue, and they are popped and checked after the clock edge.
module tb_pulse_throttle;

  localparam int unsigned CntW = 2;
  localparam int unsigned Gap  = 8;

  logic            clka = 1'b0;
  logic            rstna = 1'b0;
  logic            evt_in = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            a_pul;
  logic [CntW-1:0] pend;
  logic            ovf;
  logic            busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic            a;
    logic [CntW-1:0] p;
    logic            o;
    logic            b;
    string           tag;
  } exp_t;

  exp_t sb[$];

  pulse_throttle #(
    .CNT_W (CntW),
    .GAP   (Gap)
  ) dut (
    .clka    (clka),
    .rstna   (rstna),
    .evt_in  (evt_in),
    .en      (en),
    .flush   (flush),
    .ovf_clr (ovf_clr),
    .a_pul   (a_pul),
    .pend    (pend),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clka = ~clka;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic expect_now(input logic ea, input logic [CntW-1:0] ep, input logic eo,
                            input logic eb, input string tag);
    exp_t e;
    e.a = ea; e.p = ep; e.o = eo; e.b = eb; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL scoreboard: queue empty, got 0 entries, need 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (a_pul === e.a) else begin
        fails++;
        $error("FAIL %s a_pul: got %b exp %b", e.tag, a_pul, e.a);
      end
      tests++;
      assert (pend === e.p) else begin
        fails++;
        $error("FAIL %s pend: got %0d exp %0d", e.tag, pend, e.p);
      end
      tests++;
      assert (ovf === e.o) else begin
        fails++;
        $error("FAIL %s ovf: got %b exp %b", e.tag, ovf, e.o);
      end
      tests++;
      assert (busy === e.b) else begin
        fails++;
        $error("FAIL %s busy: got %b exp %b", e.tag, busy, e.b);
      end
    end
  endtask

  // Drive inputs on the falling edge, then check just after the rising edge.
  task automatic step(input logic e_v, input logic en_v, input logic fl_v, input logic oc_v,
                      input logic ea, input logic [CntW-1:0] ep, input logic eo,
                      input logic eb, input string tag);
    @(negedge clka);
    evt_in = e_v; en = en_v; flush = fl_v; ovf_clr = oc_v;
    expect_now(ea, ep, eo, eb, tag);
    @(posedge clka);
    #1;
    check_pop();
  endtask

  initial begin
    logic [CntW-1:0] ep;

    // Reset state
    #2;
    expect_now(1'b0, 2'd0, 1'b0, 1'b0, "reset");
    check_pop();
    @(negedge clka);
    rstna = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "idle");

    // Single event: bypass pulse, busy until HOLD expires 7 edges later
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "single_fire");
    for (int i = 1; i <= 7; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, (i < 7), "single_hold");

    // Burst of 3: pulses at edges 0, 8, 16
    for (int i = 0; i <= 23; i++) begin
      if (i == 0) ep = 2'd0;
      else if (i == 1) ep = 2'd1;
      else if (i < 8) ep = 2'd2;
      else if (i < 16) ep = 2'd1;
      else ep = 2'd0;
      step((i < 3), 1'b1, 1'b0, 1'b0, (i == 0 || i == 8 || i == 16), ep, 1'b0, (i < 23),
           "burst");
    end

    // Saturation: 6 events, ovf at edge 4, ovf_clr loses to a lost event at edge 5
    for (int i = 0; i <= 31; i++) begin
      if (i == 0) ep = 2'd0;
      else if (i == 1) ep = 2'd1;
      else if (i == 2) ep = 2'd2;
      else if (i < 8) ep = 2'd3;
      else if (i < 16) ep = 2'd2;
      else if (i < 24) ep = 2'd1;
      else ep = 2'd0;
      step((i < 6), 1'b1, 1'b0, (i == 5 || i == 6),
           (i == 0 || i == 8 || i == 16 || i == 24), ep, (i == 4 || i == 5), (i < 31), "sat");
    end

    // Simultaneous: pend=2 with evt_in on the firing edge keeps pend at 2
    for (int i = 0; i <= 25; i++) begin
      if (i == 0) ep = 2'd1;
      else if (i < 10) ep = 2'd2;
      else if (i < 18) ep = 2'd1;
      else ep = 2'd0;
      step((i < 3), (i >= 2), 1'b0, 1'b0, (i == 2 || i == 10 || i == 18), ep, 1'b0, (i < 25),
           "simul");
    end

    // Flush: accumulate with en=0, flush together with an event, then enable
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, "en0_acc");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, "en0_acc");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, "en0_acc");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "flush_evt");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "post_flush");

    // Reset mid-operation: in HOLD with pend=3
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, "pre_rst");
    evt_in = 1'b0;
    #1;
    rstna = 1'b0;
    #1;
    expect_now(1'b0, 2'd0, 1'b0, 1'b0, "async_rst");
    check_pop();
    @(negedge clka);
    rstna = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "post_rst");

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain: got %0d left, need 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
